split_data: RTL and testbench

- Read-side inverse of the write-path pixel packer. Takes OSIZE-bit words from the AXI VDMA read-data FIFO and emits ISIZE-bit pixels, MSB-first.
- The first pixel of a line or frame is taken from idata[OSIZE-1 -: ISIZE]. Pixels may straddle word boundaries when OSIZE%ISIZE != 0.
- Sits between the read-channel data FIFO and the video stream output. Input and output both use valid/ready handshakes.

---
 rtl/vdma_map_pkg.sv | 20 ++
 rtl/split_shift_buf.sv | 59 +++++
 rtl/split_data.sv | 80 ++++++++
 tb/tb_split_data.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdma_map_pkg.sv
// Shared constants for the VDMA pixel pack/unpack datapaths.
// Mode tags are common to the write-side packer and read-side splitter.
package vdma_map_pkg;

  localparam int ISIZE_DEF = 24;
  localparam int OSIZE_DEF = 256;
  localparam int NSIZE = OSIZE_DEF / ISIZE_DEF;
  localparam int CNT_W = $clog2(OSIZE_DEF + ISIZE_DEF);

  localparam logic [31:0] MODE_LINE = "LINE";
  localparam logic [31:0] MODE_ONCE = "ONCE";

  function automatic int cnt_width(
    input int osize,
    input int isize
  );
    return $clog2(osize + isize);
  endfunction

endpackage

// File: rtl/split_shift_buf.sv
// Left-justified bit buffer: pop shifts out one pixel, push appends a word
// directly below whatever survives the same-cycle pop.
module split_shift_buf
  import vdma_map_pkg::*;
#(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256,
  localparam int BW = OSIZE + ISIZE,
  localparam int CW = cnt_width(OSIZE, ISIZE)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_pop,
  input  logic             i_push,
  input  logic [OSIZE-1:0] i_data,
  output logic [ISIZE-1:0] o_pix,
  output logic [CW-1:0]    o_cnt
);

  localparam logic [CW-1:0] L_I = CW'(ISIZE);
  localparam logic [CW-1:0] L_O = CW'(OSIZE);

  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_cnt;

  logic [BW-1:0] w_buf_pop;
  logic [BW-1:0] w_ins;
  logic [BW-1:0] w_buf_nxt;
  logic [CW-1:0] w_cnt_pop;
  logic [CW-1:0] w_cnt_nxt;

  // Bits below the valid region are always zero, so OR-merge is safe.
  always_comb begin
    w_buf_pop = i_pop ? (r_buf << ISIZE) : r_buf;
    w_cnt_pop = i_pop ? (r_cnt - L_I) : r_cnt;
    w_ins     = {i_data, {ISIZE{1'b0}}} >> w_cnt_pop;
    w_buf_nxt = w_buf_pop;
    w_cnt_nxt = w_cnt_pop;
    if (i_push) begin
      w_buf_nxt = w_buf_pop | w_ins;
      w_cnt_nxt = w_cnt_pop + L_O;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n || i_clr) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_pix = r_buf[BW-1 -: ISIZE];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/split_data.sv
// Read-side pixel splitter: OSIZE-bit VDMA words in, ISIZE-bit pixels out,
// MSB-first, with optional per-line realignment.
module split_data
  import vdma_map_pkg::*;
#(
  parameter int          ISIZE = 24,
  parameter int          OSIZE = 256,
  parameter logic [31:0] MODE  = MODE_LINE
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ialign,
  input  logic             ivalid,
  input  logic [OSIZE-1:0] idata,
  input  logic             ilast,
  output logic             iready,
  output logic             ovalid,
  output logic [ISIZE-1:0] odata,
  output logic             olast,
  input  logic             oready
);

  localparam int CW = cnt_width(OSIZE, ISIZE);
  localparam logic [CW-1:0] L_I  = CW'(ISIZE);
  localparam logic [CW:0]   L_2I = (CW+1)'(2 * ISIZE);
  localparam bit LINE_EN = (MODE == MODE_LINE);

  logic [ISIZE-1:0] w_pix;
  logic [CW-1:0]    w_cnt;
  logic             r_line_pend;

  logic w_ovalid;
  logic w_olast;
  logic w_lt2;
  logic w_pop;
  logic w_push;
  logic w_iready;
  logic w_clr;

  assign w_ovalid = (w_cnt >= L_I);
  assign w_lt2    = ({1'b0, w_cnt} < L_2I);
  assign w_olast  = w_ovalid & r_line_pend & w_lt2;
  assign w_pop    = w_ovalid & oready & ~ialign;

  // oready feeds iready directly so a refill lands on the draining pop.
  assign w_iready = rst_n & ~r_line_pend & ~ialign &
                    (~w_ovalid | (w_lt2 & w_ovalid & oready));
  assign w_push   = ivalid & w_iready;

  assign w_clr = ialign | (w_pop & w_olast) |
                 (r_line_pend & ~w_ovalid);

  split_shift_buf #(
    .ISIZE(ISIZE),
    .OSIZE(OSIZE)
  ) u_buf (
    .clock (clock),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_pop (w_pop),
    .i_push(w_push),
    .i_data(idata),
    .o_pix (w_pix),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clock) begin
    if (!rst_n || w_clr) begin
      r_line_pend <= 1'b0;
    end else if (w_push && ilast && LINE_EN) begin
      r_line_pend <= 1'b1;
    end
  end

  assign iready = w_iready;
  assign ovalid = rst_n & w_ovalid;
  assign olast  = rst_n & w_olast;
  assign odata  = rst_n ? w_pix : '0;

endmodule

// File: tb/tb_split_data.sv
// Directed bench for split_data: ONCE/LINE at 24-bit and LINE at 32-bit.
module tb_split_data;
  import vdma_map_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ia[3];
  logic iv[3];
  logic il[3];
  logic ordy[3];
  logic [255:0] id[3];
  wire ir[3];
  wire ov[3];
  wire ol[3];
  wire [23:0] od0;
  wire [23:0] od1;
  wire [31:0] od2;

  split_data #(.ISIZE(24), .OSIZE(256), .MODE("ONCE")) u_once (
    .clock(clk), .rst_n(rst_n), .ialign(ia[0]), .ivalid(iv[0]),
    .idata(id[0]), .ilast(il[0]), .iready(ir[0]), .ovalid(ov[0]),
    .odata(od0), .olast(ol[0]), .oready(ordy[0]));

  split_data #(.ISIZE(24), .OSIZE(256), .MODE("LINE")) u_line (
    .clock(clk), .rst_n(rst_n), .ialign(ia[1]), .ivalid(iv[1]),
    .idata(id[1]), .ilast(il[1]), .iready(ir[1]), .ovalid(ov[1]),
    .odata(od1), .olast(ol[1]), .oready(ordy[1]));

  split_data #(.ISIZE(32), .OSIZE(256), .MODE("LINE")) u_w32 (
    .clock(clk), .rst_n(rst_n), .ialign(ia[2]), .ivalid(iv[2]),
    .idata(id[2]), .ilast(il[2]), .iready(ir[2]), .ovalid(ov[2]),
    .odata(od2), .olast(ol[2]), .oready(ordy[2]));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] wq[$];
  bit           lq[$];
  logic [31:0]  expq[$];
  bit           exlq[$];
  int           cycq[$];
  int           pushq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] g_od(input int s);
    case (s)
      0: return {8'h0, od0};
      1: return {8'h0, od1};
      default: return od2;
    endcase
  endfunction

  task automatic clr_q();
    wq.delete(); lq.delete(); expq.delete(); exlq.delete();
  endtask

  // 32 x 24-bit pixels packed into exactly three words.
  task automatic load_frame(input int base, input bit line);
    logic [767:0] st;
    for (int i = 0; i < 32; i++) begin
      st[767-24*i -: 24] = 24'(base + i);
      expq.push_back(32'(base + i));
      exlq.push_back(line && i == 31);
    end
    wq.push_back(st[767:512]); lq.push_back(1'b0);
    wq.push_back(st[511:256]); lq.push_back(1'b0);
    wq.push_back(st[255:0]);   lq.push_back(line);
  endtask

  task automatic load_line24(input int base);
    logic [255:0] w;
    for (int i = 0; i < 10; i++) begin
      w[255-24*i -: 24] = 24'(base + i);
      expq.push_back(32'(base + i));
      exlq.push_back(i == 9);
    end
    w[15:0] = 16'hBEEF;
    wq.push_back(w); lq.push_back(1'b1);
  endtask

  task automatic load_w32(input int base, input bit last);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) begin
      w[255-32*i -: 32] = 32'hC0DE0000 + 32'(base + i);
      expq.push_back(32'hC0DE0000 + 32'(base + i));
      exlq.push_back(last && i == 7);
    end
    wq.push_back(w); lq.push_back(last);
  endtask

  // Feeds wq, checks every visible pixel against expq, logs pops/pushes.
  task automatic run(input int s, input bit tog, input int g0, input int g1);
    int c = 0;
    int np = 0;
    bit done = 1'b0;
    bit pushed;
    cycq.delete(); pushq.delete();
    while (!done && c < 400) begin
      iv[s] = (wq.size() > 0) && !(c >= g0 && c < g1);
      id[s] = (wq.size() > 0) ? wq[0] : '0;
      il[s] = (lq.size() > 0) ? lq[0] : 1'b0;
      ordy[s] = tog ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      pushed = iv[s] && ir[s];
      if (ov[s]) begin
        if (np < expq.size()) begin
          chk($sformatf("s%0d px%0d", s, np), g_od(s), expq[np]);
          chk($sformatf("s%0d last%0d", s, np), ol[s], exlq[np]);
        end else begin
          chk($sformatf("s%0d extra", s), np, expq.size());
        end
        if (ordy[s]) begin
          cycq.push_back(cyc);
          np++;
        end
      end
      if (pushed) begin
        pushq.push_back(np);
        void'(wq.pop_front());
        void'(lq.pop_front());
      end
      done = (wq.size() == 0) && !ov[s] && !pushed;
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("s%0d finished", s), done, 1);
    chk($sformatf("s%0d npix", s), np, expq.size());
    iv[s] = 1'b0;
    ordy[s] = 1'b0;
  endtask

  initial begin
    logic [255:0] wa;
    logic [255:0] wy;
    for (int s = 0; s < 3; s++) begin
      ia[s] = 0; iv[s] = 0; il[s] = 0; ordy[s] = 0; id[s] = '0;
    end
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst ov%0d", s), ov[s], 0);
      chk($sformatf("rst ir%0d", s), ir[s], 0);
      chk($sformatf("rst ol%0d", s), ol[s], 0);
      chk($sformatf("rst od%0d", s), g_od(s), 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst ir", ir[0], 1);
    chk("post rst ov", ov[0], 0);

    // ONCE, back-to-back, no stall
    clr_q(); load_frame(0, 1'b0);
    run(0, 1'b0, 0, 0);
    chk("once span", cycq[31] - cycq[0], 31);
    chk("once pushes", pushq.size(), 3);
    chk("once push1", pushq[1], 10);
    chk("once push2", pushq[2], 21);
    chk("once empty ov", ov[0], 0);
    chk("once empty ir", ir[0], 1);

    // LINE, one-word lines with 16 bits of residual
    clr_q(); load_line24(100); load_line24(200);
    run(1, 1'b0, 0, 0);
    chk("line1 push1", pushq[1], 10);
    chk("line1 bubble", cycq[10] - cycq[9], 2);

    // LINE, 3-word line twice
    clr_q(); load_frame(0, 1'b1); load_frame(0, 1'b1);
    run(1, 1'b0, 0, 0);
    chk("line3 push3", pushq[3], 32);
    chk("line3 span", cycq[31] - cycq[0], 31);
    chk("line3 bubble", cycq[32] - cycq[31], 2);

    // ONCE with oready toggling and an ivalid gap
    clr_q(); load_frame(0, 1'b0);
    run(0, 1'b1, 3, 9);

    // 32-bit pixels, two-word line
    clr_q(); load_w32(0, 1'b0); load_w32(8, 1'b1);
    run(2, 1'b0, 0, 0);
    chk("w32 span", cycq[15] - cycq[0], 15);
    chk("w32 push1", pushq[1], 8);

    // ialign mid-word drops the word and resets pixel phase
    for (int i = 0; i < 10; i++) wa[255-24*i -: 24] = 24'(i);
    wa[15:0] = 16'hBEEF;
    wy = '0;
    wy[255:232] = 24'hABCDEF;
    il[1] = 0; ordy[1] = 1; iv[1] = 1; id[1] = wa;
    @(negedge clk);
    chk("al ir", ir[1], 1);
    @(posedge clk); #1;
    iv[1] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("al px%0d", k), od1, k);
    end
    @(posedge clk); #1;
    ia[1] = 1; iv[1] = 1; id[1] = wy;
    @(negedge clk);
    chk("al block ir", ir[1], 0);
    @(posedge clk); #1;
    ia[1] = 0; iv[1] = 0;
    @(negedge clk);
    chk("al cleared ov", ov[1], 0);
    @(posedge clk); #1;
    iv[1] = 1;
    @(negedge clk);
    chk("al next ir", ir[1], 1);
    @(posedge clk); #1;
    iv[1] = 0;
    @(negedge clk);
    chk("al next ov", ov[1], 1);
    chk("al next px0", od1, 24'hABCDEF);
    @(posedge clk); #1;
    ia[1] = 1;
    @(posedge clk); #1;
    ia[1] = 0; ordy[1] = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
